// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS encoding constants: request kinds, opcodes, functs, error codes.
// The pipeline's type decoder imports the same package so the two cannot drift.
package mips_enc_pkg;

  localparam logic [3:0] KIND_NOP  = 4'd0;
  localparam logic [3:0] KIND_LW   = 4'd1;
  localparam logic [3:0] KIND_SW   = 4'd2;
  localparam logic [3:0] KIND_ADDU = 4'd3;
  localparam logic [3:0] KIND_SUBU = 4'd4;
  localparam logic [3:0] KIND_ORI  = 4'd5;
  localparam logic [3:0] KIND_LUI  = 4'd6;
  localparam logic [3:0] KIND_BEQ  = 4'd7;
  localparam logic [3:0] KIND_J    = 4'd8;
  localparam logic [3:0] KIND_JAL  = 4'd9;
  localparam logic [3:0] KIND_JR   = 4'd10;
  localparam logic [3:0] KIND_LI   = 4'd11;
  localparam logic [3:0] KIND_MOVE = 4'd12;
  localparam logic [3:0] KIND_MULT = 4'd13;
  localparam logic [3:0] KIND_MFLO = 4'd14;
  localparam logic [3:0] KIND_BAD  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_KIND   = 2'd1;
  localparam logic [1:0] ERR_BRANCH = 2'd2;
  localparam logic [1:0] ERR_JUMP   = 2'd3;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_EMIT2} state_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
  } fields_t;

endpackage

// File: rtl/mips_instr_encoder_field_pack.sv
// Combinational R/I/J word packer; shamt is always zero.
module instr_field_pack
  import mips_enc_pkg::*;
(
  input  fields_t     fields,
  output logic [31:0] word
);

  always_comb begin
    word = 32'd0;
    case (fields.fmt)
      FMT_R:   word = {OP_RTYPE, fields.rs, fields.rt, fields.rd, 5'd0, fields.funct};
      FMT_I:   word = {fields.op, fields.rs, fields.rt, fields.imm16};
      FMT_J:   word = {fields.op, fields.target26};
      default: word = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder: one request in, one or two words out with byte addresses.
// Words are registered (accept at N, valid at N+1); in_ready drops while an LI pair is in flight.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        org_load,
  input  logic [31:0] org_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [1:0]  err_code
);

  state_e      state, state_nx;
  logic [31:0] addr_cnt;
  logic [31:0] pend_word;
  logic [31:0] cur_addr;
  logic [31:0] next_pc;
  logic [31:0] br_diff;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        org_ok;
  logic        accept;
  logic        out_fire;
  logic        two_words;
  logic [1:0]  err_nx;
  fields_t     f1;
  fields_t     f2;

  assign out_fire = out_valid && out_ready;
  assign in_ready = !reset && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // A retarget only lands when nothing is queued, so no emitted word ever changes address.
  assign org_ok   = org_load && (state == ST_IDLE) && !out_valid;
  assign cur_addr = org_ok ? (org_addr & 32'hFFFF_FFFC) : addr_cnt;
  assign next_pc  = cur_addr + 32'd4;
  assign br_diff  = in_imm - next_pc;

  always_comb begin
    f1        = '0;
    f1.fmt    = FMT_R;
    f2        = '0;
    f2.fmt    = FMT_I;
    f2.op     = OP_ORI;
    f2.rs     = in_rt;
    f2.rt     = in_rt;
    f2.imm16  = in_imm[15:0];
    two_words = 1'b0;
    err_nx    = ERR_NONE;
    case (in_kind)
      KIND_NOP: ;
      KIND_LW, KIND_SW, KIND_ORI: begin
        f1.fmt   = FMT_I;
        f1.op    = (in_kind == KIND_LW) ? OP_LW : (in_kind == KIND_SW) ? OP_SW : OP_ORI;
        f1.rs    = in_rs;
        f1.rt    = in_rt;
        f1.imm16 = in_imm[15:0];
      end
      KIND_LUI: begin
        f1.fmt   = FMT_I;
        f1.op    = OP_LUI;
        f1.rt    = in_rt;
        f1.imm16 = in_imm[15:0];
      end
      KIND_ADDU, KIND_SUBU: begin
        f1.rs    = in_rs;
        f1.rt    = in_rt;
        f1.rd    = in_rd;
        f1.funct = (in_kind == KIND_ADDU) ? FN_ADDU : FN_SUBU;
      end
      KIND_MOVE: begin
        f1.rs    = in_rs;
        f1.rd    = in_rd;
        f1.funct = FN_ADDU;
      end
      KIND_BEQ: begin
        f1.fmt   = FMT_I;
        f1.op    = OP_BEQ;
        f1.rs    = in_rs;
        f1.rt    = in_rt;
        f1.imm16 = br_diff[17:2];
        // Word offset fits 16 signed bits iff diff[31:17] is a pure sign extension.
        if ((br_diff[1:0] != 2'b00) || !((&br_diff[31:17]) || !(|br_diff[31:17])))
          err_nx = ERR_BRANCH;
      end
      KIND_J, KIND_JAL: begin
        f1.fmt      = FMT_J;
        f1.op       = (in_kind == KIND_J) ? OP_J : OP_JAL;
        f1.target26 = in_imm[27:2];
        if ((in_imm[1:0] != 2'b00) || (in_imm[31:28] != next_pc[31:28]))
          err_nx = ERR_JUMP;
      end
      KIND_JR: begin
        f1.rs    = in_rs;
        f1.funct = FN_JR;
      end
      KIND_MULT: begin
        f1.rs    = in_rs;
        f1.rt    = in_rt;
        f1.funct = FN_MULT;
      end
      KIND_MFLO: begin
        f1.rd    = in_rd;
        f1.funct = FN_MFLO;
      end
      KIND_LI: begin
        f1.fmt = FMT_I;
        f1.rt  = in_rt;
        if (in_imm[31:16] == 16'd0) begin
          f1.op    = OP_ORI;
          f1.imm16 = in_imm[15:0];
        end else begin
          f1.op     = OP_LUI;
          f1.imm16  = in_imm[31:16];
          two_words = (in_imm[15:0] != 16'd0);
        end
      end
      default: err_nx = ERR_KIND;
    endcase
  end

  instr_field_pack u_pack_first (
    .fields (f1),
    .word   (word1)
  );

  instr_field_pack u_pack_second (
    .fields (f2),
    .word   (word2)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept && (err_nx == ERR_NONE) && two_words) state_nx = ST_EMIT;
      ST_EMIT:  if (out_fire) state_nx = ST_EMIT2;
      ST_EMIT2: if (out_fire) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // addr_cnt is the address the next accepted word will occupy.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_word  <= 32'd0;
      out_addr  <= BASE_ADDR;
      addr_cnt  <= BASE_ADDR;
      pend_word <= 32'd0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err <= 1'b0;
      if (org_ok)   addr_cnt  <= cur_addr;
      if (out_fire) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (err_nx != ERR_NONE) begin
              err      <= 1'b1;
              err_code <= err_nx;
            end else begin
              out_valid <= 1'b1;
              out_word  <= word1;
              out_addr  <= cur_addr;
              pend_word <= word2;
              addr_cnt  <= two_words ? (cur_addr + 32'd8) : next_pc;
            end
          end
        end
        ST_EMIT: begin
          if (out_fire) begin
            out_valid <= 1'b1;
            out_word  <= pend_word;
            out_addr  <= out_addr + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench: directed spec cases plus randomized requests against an arithmetic model.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        org_load;
  logic [31:0] org_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err;
  logic [1:0]  err_code;

  int checks;
  int failures;
  int cyc_cnt = 0;
  bit rnd_ready;
  logic [31:0] got_w[$];
  logic [31:0] got_a[$];
  int          got_e[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mips_instr_encoder #(.BASE_ADDR(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .org_load(org_load), .org_addr(org_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err), .err_code(err_code)
  );

  // Inputs only change 1 time unit after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        got_w.push_back(out_word);
        got_a.push_back(out_addr);
      end
      if (err) got_e.push_back(int'(err_code));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    got_w.delete();
    got_a.delete();
    got_e.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; org_load = 1'b0; out_ready = 1'b1;
    cyc(2);
    reset = 1'b0;
    clear_seen();
  endtask

  task automatic settle();
    out_ready = 1'b1;
    cyc(6);
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [31:0] imm);
    bit done = 0;
    in_kind = k; in_rs = s; in_rt = t; in_rd = d; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout kind=%0d never accepted", k);
    end
  endtask

  function automatic logic [31:0] rword(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input int fn);
    return 32'(s) * 32'h0020_0000 + 32'(t) * 32'h0001_0000 + 32'(d) * 32'h0000_0800 + 32'(fn);
  endfunction

  function automatic logic [31:0] iword(input int op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [31:0] imm);
    return 32'(op) * 32'h0400_0000 + 32'(s) * 32'h0020_0000 + 32'(t) * 32'h0001_0000 + (imm % 32'h1_0000);
  endfunction

  // Reference: words emitted (n), and error code, for a request issued at address a.
  task automatic model(input int k, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [31:0] imm, input logic [31:0] a,
                       output int n, output logic [31:0] w0, output logic [31:0] w1, output int ec);
    logic [31:0] diff, hi, lo;
    int sd, q;
    n = 1; w0 = 0; w1 = 0; ec = 0;
    hi = imm / 32'h1_0000;
    lo = imm % 32'h1_0000;
    case (k)
      0:  w0 = 0;
      1:  w0 = iword(35, s, t, imm);
      2:  w0 = iword(43, s, t, imm);
      3:  w0 = rword(s, t, d, 33);
      4:  w0 = rword(s, t, d, 35);
      5:  w0 = iword(13, s, t, imm);
      6:  w0 = iword(15, 0, t, imm);
      7: begin
        diff = imm - (a + 4);
        sd = int'(diff);
        q = sd / 4;
        if ((sd % 4) != 0 || q < -32768 || q > 32767) ec = 2;
        else w0 = iword(4, s, t, 32'(q));
      end
      8, 9: begin
        if ((imm % 4) != 0 || (imm / 32'h1000_0000) != ((a + 4) / 32'h1000_0000)) ec = 3;
        else w0 = 32'(k - 6) * 32'h0400_0000 + (imm % 32'h1000_0000) / 4;
      end
      10: w0 = rword(s, 0, 0, 8);
      11: begin
        if (hi == 0) w0 = iword(13, 0, t, lo);
        else begin
          w0 = iword(15, 0, t, hi);
          if (lo != 0) begin
            n = 2;
            w1 = iword(13, t, t, lo);
          end
        end
      end
      12: w0 = rword(s, 0, d, 33);
      13: w0 = rword(s, t, 0, 24);
      14: w0 = rword(0, 0, d, 18);
      default: ec = 1;
    endcase
    if (ec != 0) n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_word !== 32'h0) begin failures++; $display("FAIL reset_out_word got=%h exp=0", out_word); end
    checks++; if (out_addr !== 32'h3000) begin failures++; $display("FAIL reset_out_addr got=%h exp=3000", out_addr); end
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", err, err_code); end
    reset = 1'b0;
    cyc(1);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    clear_seen();
  endtask

  task automatic test_addu();
    do_reset();
    send(3, 1, 2, 3, 0);
    send(0, 0, 0, 0, 0);
    settle();
    checks++; if (got_w.size() != 2) begin failures++; $display("FAIL addu_count got=%0d exp=2", got_w.size()); end
    else begin
      checks++; if (got_w[0] !== 32'h0022_1821 || got_a[0] !== 32'h3000) begin failures++; $display("FAIL addu_word got=%h@%h exp=00221821@3000", got_w[0], got_a[0]); end
      checks++; if (got_a[1] !== 32'h3004) begin failures++; $display("FAIL addu_next_addr got=%h exp=3004", got_a[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_reset();
    t0 = cyc_cnt;
    for (int i = 0; i < 4; i++) send(4, 5'(i), 5'(i + 1), 5'(i + 2), 0);
    checks++; if (cyc_cnt - t0 != 4) begin failures++; $display("FAIL b2b_cycles got=%0d exp=4", cyc_cnt - t0); end
    settle();
    checks++; if (got_w.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got_w.size()); end
    for (int i = 0; i < 4 && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== rword(5'(i), 5'(i + 1), 5'(i + 2), 35) || got_a[i] !== 32'h3000 + 32'(4 * i)) begin
        failures++; $display("FAIL b2b_word%0d got=%h@%h", i, got_w[i], got_a[i]);
      end
    end
  endtask

  task automatic test_li();
    logic [31:0] ew[4] = '{32'h3C08_1234, 32'h3508_5678, 32'h3408_BEEF, 32'h3C08_ABCD};
    do_reset();
    send(11, 0, 8, 0, 32'h1234_5678);
    send(11, 0, 8, 0, 32'h0000_BEEF);
    send(11, 0, 8, 0, 32'hABCD_0000);
    settle();
    checks++; if (got_w.size() != 4) begin failures++; $display("FAIL li_count got=%0d exp=4", got_w.size()); end
    for (int i = 0; i < 4 && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== ew[i] || got_a[i] !== 32'h3000 + 32'(4 * i)) begin
        failures++; $display("FAIL li_word%0d got=%h@%h exp=%h", i, got_w[i], got_a[i], ew[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [31:0] ew[6] = '{32'h0, 32'h0, 32'h1022_FFFD, 32'h0, 32'h1022_7FFF, 32'h1022_8000};
    do_reset();
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(7, 1, 2, 0, 32'h0000_3000);
    send(7, 1, 2, 0, 32'h0000_3002);
    checks++; if (err !== 1'b1 || err_code !== 2'd2) begin failures++; $display("FAIL beq_misalign_err got=%b/%0d exp=1/2", err, err_code); end
    send(0, 0, 0, 0, 0);
    send(7, 1, 2, 0, 32'h0002_3010);
    send(7, 1, 2, 0, 32'h0002_3018);
    send(7, 1, 2, 0, 32'hFFFE_3018);
    settle();
    checks++; if (got_w.size() != 6) begin failures++; $display("FAIL beq_count got=%0d exp=6", got_w.size()); end
    for (int i = 0; i < 6 && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== ew[i] || got_a[i] !== 32'h3000 + 32'(4 * i)) begin
        failures++; $display("FAIL beq_word%0d got=%h@%h exp=%h", i, got_w[i], got_a[i], ew[i]);
      end
    end
    checks++; if (got_e.size() != 2 || got_e[0] != 2 || got_e[1] != 2) begin failures++; $display("FAIL beq_errs got=%0d exp=2 pulses of code 2", got_e.size()); end
  endtask

  task automatic test_jump();
    do_reset();
    send(8, 0, 0, 0, 32'h0000_3010);
    send(8, 0, 0, 0, 32'h1000_0000);
    send(9, 0, 0, 0, 32'h0000_3001);
    checks++; if (err_code !== 2'd3) begin failures++; $display("FAIL jump_err_code got=%0d exp=3", err_code); end
    send(9, 0, 0, 0, 32'h0FFF_FFFC);
    send(10, 31, 7, 7, 32'hFFFF_FFFF);
    settle();
    checks++; if (got_w.size() != 3) begin failures++; $display("FAIL jump_count got=%0d exp=3", got_w.size()); end
    else begin
      checks++; if (got_w[0] !== 32'h0800_0C04 || got_a[0] !== 32'h3000) begin failures++; $display("FAIL j_word got=%h@%h exp=08000c04@3000", got_w[0], got_a[0]); end
      checks++; if (got_w[1] !== 32'h0FFF_FFFF || got_a[1] !== 32'h3004) begin failures++; $display("FAIL jal_word got=%h@%h exp=0fffffff@3004", got_w[1], got_a[1]); end
      checks++; if (got_w[2] !== 32'h03E0_0008 || got_a[2] !== 32'h3008) begin failures++; $display("FAIL jr_word got=%h@%h exp=03e00008@3008", got_w[2], got_a[2]); end
    end
    checks++; if (got_e.size() != 2) begin failures++; $display("FAIL jump_err_pulses got=%0d exp=2", got_e.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(11, 0, 8, 0, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++;
      if (out_valid !== 1'b1 || out_word !== 32'h3C08_1234 || out_addr !== 32'h3000 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_first c%0d got v=%b %h@%h rdy=%b", i, out_valid, out_word, out_addr, in_ready);
      end
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++;
      if (out_valid !== 1'b1 || out_word !== 32'h3508_5678 || out_addr !== 32'h3004 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_second c%0d got v=%b %h@%h rdy=%b", i, out_valid, out_word, out_addr, in_ready);
      end
    end
    out_ready = 1'b1;
    cyc(1);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got rdy=%b v=%b exp 1/0", in_ready, out_valid); end
    settle();
    checks++; if (got_w.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", got_w.size()); end
  endtask

  task automatic test_org();
    do_reset();
    org_load = 1'b1;
    org_addr = 32'h0040_0003;
    send(0, 0, 0, 0, 0);
    org_load = 1'b0;
    send(0, 0, 0, 0, 0);
    settle();
    out_ready = 1'b0;
    send(0, 0, 0, 0, 0);
    org_load = 1'b1;
    org_addr = 32'h0000_5000;
    cyc(1);
    org_load = 1'b0;
    out_ready = 1'b1;
    send(0, 0, 0, 0, 0);
    settle();
    checks++; if (got_a.size() != 4) begin failures++; $display("FAIL org_count got=%0d exp=4", got_a.size()); end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== 32'h0040_0000 + 32'(4 * i) || got_w[i] !== 32'h0) begin
        failures++; $display("FAIL org_addr%0d got=%h@%h exp=0@%h", i, got_w[i], got_a[i], 32'h0040_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_bad_kind();
    do_reset();
    send(15, 1, 2, 3, 32'h1234);
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL bad_kind_err got=%b/%0d exp=1/1", err, err_code); end
    cyc(1);
    checks++; if (err !== 1'b0 || err_code !== 2'd1) begin failures++; $display("FAIL bad_kind_hold got=%b/%0d exp=0/1", err, err_code); end
    settle();
    checks++; if (got_w.size() != 0) begin failures++; $display("FAIL bad_kind_words got=%0d exp=0", got_w.size()); end
  endtask

  task automatic test_reset_mid_li();
    do_reset();
    out_ready = 1'b0;
    send(11, 0, 8, 0, 32'h1234_5678);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    reset = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midli_in_ready got=%b exp=0", in_ready); end
    cyc(1);
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3000) begin failures++; $display("FAIL midli_reset got v=%b addr=%h exp 0/3000", out_valid, out_addr); end
    reset = 1'b0;
    out_ready = 1'b1;
    send(0, 0, 0, 0, 0);
    settle();
    checks++;
    if (got_w.size() != 2 || got_w[0] !== 32'h3C08_1234 || got_w[1] !== 32'h0 || got_a[1] !== 32'h3000) begin
      failures++; $display("FAIL midli_stream got=%0d words, last addr=%h exp 2 words, NOP@3000", got_w.size(), got_a[got_a.size() - 1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_w[$], exp_a[$], maddr, imm, w0, w1;
    int exp_e[$], n, ec, k, sel;
    logic [4:0] s, t, d;
    do_reset();
    maddr = 32'h3000;
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 15);
      s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
      imm = $urandom;
      sel = $urandom_range(0, 4);
      if (k == 7) begin
        case (sel)
          0: imm = maddr + 4 + 32'((int'($urandom_range(0, 65535)) - 32768) * 4);
          1: imm = maddr + 4 + 32'(32768 * 4);
          2: imm = maddr + 4 - 32'(32769 * 4);
          3: imm = maddr + 4 + 32'($urandom_range(0, 100) * 4) + 2;
          default: ;
        endcase
      end else if (k == 8 || k == 9) begin
        if (sel < 2) imm = ((maddr + 4) & 32'hF000_0000) | (imm & 32'h0FFF_FFFC);
        else if (sel == 2) imm = ((maddr + 4) & 32'hF000_0000) | (imm & 32'h0FFF_FFFF) | 32'd1;
      end else if (k == 11) begin
        if (sel == 0) imm = imm % 32'h1_0000;
        else if (sel == 1) imm = imm & 32'hFFFF_0000;
      end
      model(k, s, t, d, imm, maddr, n, w0, w1, ec);
      if (ec != 0) exp_e.push_back(ec);
      if (n >= 1) begin exp_w.push_back(w0); exp_a.push_back(maddr); end
      if (n == 2) begin exp_w.push_back(w1); exp_a.push_back(maddr + 4); end
      maddr = maddr + 32'(4 * n);
      send(4'(k), s, t, d, imm);
    end
    rnd_ready = 0;
    settle();
    checks++; if (got_w.size() != exp_w.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_a[i] !== exp_a[i]) begin
        failures++; $display("FAIL rand_word%0d got=%h@%h exp=%h@%h", i, got_w[i], got_a[i], exp_w[i], exp_a[i]);
      end
    end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL rand_err_count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
    for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
      checks++;
      if (got_e[i] != exp_e[i]) begin failures++; $display("FAIL rand_err%0d got=%0d exp=%0d", i, got_e[i], exp_e[i]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; rnd_ready = 0;
    reset = 1'b1; org_load = 1'b0; org_addr = 32'h0;
    in_valid = 1'b0; in_kind = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_addu();
    test_back_to_back();
    test_li();
    test_beq();
    test_jump();
    test_backpressure();
    test_org();
    test_bad_kind();
    test_reset_mid_li();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Streaming MIPS instruction encoder: accepts one abstract instruction request per handshake (kind, register fields, 32-bit immediate/target) and emits encoded 32-bit instruction words with their byte addresses for writing into instruction memory. It expands pseudo-ops (`li`, `move`) into one or two words. It also resolves branch offsets and jump targets against its own address counter. It sits in the test/boot path ahead of the IM write port and produces exactly the word classes the pipeline's type decoder classifies.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_3000, address counter value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- org_load  in  1  load address counter from org_addr (ignored unless idle with no pending output)
- org_addr  in  32  new counter value; bits [1:0] forced to 0
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_kind  in  4  request kind (see Operation)
- in_rs / in_rt / in_rd  in  5 each  register fields
- in_imm  in  32  immediate, absolute branch/jump byte target, or li value
- out_valid  out  1  word valid
- out_ready  in  1  downstream accepts word
- out_word  out  32  encoded instruction
- out_addr  out  32  byte address of out_word
- err  out  1  one-cycle pulse, request rejected, nothing emitted
- err_code  out  2  1 = unsupported kind, 2 = branch out of range/misaligned, 3 = jump region mismatch/misaligned; holds until next err

## Operation
- Kinds: 0 NOP→0x00000000; 1 LW op 100011 (rs base, rt, imm[15:0]); 2 SW op 101011; 3 ADDU funct 100001 (rd,rs,rt); 4 SUBU funct 100011; 5 ORI op 001101; 6 LUI op 001111 (rs=0); 7 BEQ op 000100; 8 J op 000010; 9 JAL op 000011; 10 JR funct 001000 (rs only); 11 LI pseudo; 12 MOVE = ADDU rd,rs,$0; 13 MULT funct 011000 (rs,rt); 14 MFLO funct 010010 (rd); 15 unsupported → err_code 1.
- Unused R-type fields and shamt are 0.
- BEQ: diff = in_imm − (addr+4). Error 2 if diff[1:0]≠0 or diff>>>2 outside signed 16 bits; else imm16 = (diff>>>2)[15:0].
- J/JAL: error 3 if in_imm[1:0]≠0 or in_imm[31:28]≠(addr+4)[31:28]; else target = in_imm[27:2].
- LI: hi=in_imm[31:16], lo=in_imm[15:0]. If hi==0: one word ORI rt,$0,lo. Else if lo==0: one word LUI rt,hi. Else two words: LUI rt,hi then ORI rt,rt,lo at addr+4.
- Address counter advances +4 on each out handshake; wraps modulo 2^32. Errors do not advance it.
- FSM: IDLE → EMIT (word 1 registered) → IDLE on out handshake, or → EMIT2 (LI second word) → IDLE on its handshake.
- Errors are detected in IDLE at acceptance; FSM stays IDLE.

## Timing
- Reset: state IDLE, out_valid 0, out_word 0, out_addr BASE_ADDR, counter BASE_ADDR, err 0, err_code 0, in_ready 0 during reset cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Latency: accept at cycle N → out_valid at N+1. Back-to-back single-word requests sustain 1 word/cycle when out_ready held high.
- out_word/out_addr stable while out_valid && !out_ready.
- LI two-word: in_ready low from acceptance until the second word's handshake.
- err asserted cycle N+1 after the rejecting acceptance.
- org_load with in_valid handshake same cycle: org_load applies first; the request encodes at org_addr.
- Reset mid-LI: second word dropped, counter back to BASE_ADDR.

## Structure
- Package mips_enc_pkg: kind constants, opcode and funct constants, err_code constants. These are shared with the type decoder so encodings cannot diverge.
- Sub-module instr_field_pack: combinational packer (R/I/J format from op, rs, rt, rd, funct, imm16, target26). The FSM, counter and offset checks live in the top.

## Test plan
- Reset, then ADDU rd=3 rs=1 rt=2 with out_ready=1 → out_word 0x00221821 at out_addr 0x3000; next request lands at 0x3004.
- LI rt=8 imm=0x12345678 → 0x3C081234 @0x3000, then 0x35085678 @0x3004; LI imm=0x0000BEEF → single 0x3408BEEF.
- BEQ rs=1 rt=2 target 0x3000 issued at 0x3008 → 0x1022FFFD. Target 0x3002 → err, err_code 2, counter unchanged.
- J target 0x0000_3010 → 0x08000C04. J target 0x1000_0000 from 0x3000 → err_code 3.
- Backpressure: hold out_ready=0 for 5 cycles during LI → words stable, in_ready 0, no duplicate or lost word.
- org_load 0x0040_0000 then NOP → 0x00000000 @0x0040_0000. Kind 15 → err_code 1. Reset during EMIT2 → out_valid 0, out_addr 0x3000.
